// File: rtl/seg_disp_sched_pkg.sv
// Shared definitions for the 7-seg display scheduler: owner states, digit
// strobe patterns, default timing and small slot helpers.
package seg_disp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] STROBE_D0 = 4'b1110;
  localparam logic [3:0] STROBE_D1 = 4'b1101;
  localparam logic [3:0] STROBE_D2 = 4'b1011;
  localparam logic [3:0] STROBE_D3 = 4'b0111;
  localparam logic [3:0] BLANK     = 4'b1111;

  localparam int DEF_SCAN_DIV = 65536;
  localparam int DEF_HOLD_CYC = 2400000;

  // Active-low strobe for a digit slot
  function automatic logic [3:0] strobe_for(input logic [1:0] idx);
    case (idx)
      2'd0:    strobe_for = STROBE_D0;
      2'd1:    strobe_for = STROBE_D1;
      2'd2:    strobe_for = STROBE_D2;
      default: strobe_for = STROBE_D3;
    endcase
  endfunction

  // BCD nibble of a digit slot
  function automatic logic [3:0] nibble_for(input logic [15:0] snap, input logic [1:0] idx);
    case (idx)
      2'd0:    nibble_for = snap[3:0];
      2'd1:    nibble_for = snap[7:4];
      2'd2:    nibble_for = snap[11:8];
      default: nibble_for = snap[15:12];
    endcase
  endfunction

  // True when this digit and every higher digit are zero (digit 0 never blanks)
  function automatic logic lead_zero(input logic [15:0] snap, input logic [1:0] idx);
    case (idx)
      2'd0:    lead_zero = 1'b0;
      2'd1:    lead_zero = (snap[15:4] == 12'd0);
      2'd2:    lead_zero = (snap[15:8] == 8'd0);
      default: lead_zero = (snap[15:12] == 4'd0);
    endcase
  endfunction

  // One-hot owner code
  function automatic logic [1:0] gnt_for(input state_t s);
    case (s)
      OWN0:    gnt_for = 2'b01;
      OWN1:    gnt_for = 2'b10;
      default: gnt_for = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/seg_disp_sched_scan_timer.sv
// Digit scan timer: scan_cnt counts 0..SCAN_DIV-1, digit_idx steps on each
// wrap; slot_wrap marks the wrap cycle and fb the wrap that closes a frame.
module seg_scan_timer
  import seg_disp_sched_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] digit_idx,
  output logic       slot_wrap,
  output logic       fb
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] scan_cnt;

  assign slot_wrap = (scan_cnt == CW'(SCAN_DIV - 1));
  assign fb        = slot_wrap && (digit_idx == 2'd3);

  // Free-running slot counter; keeps scanning in every owner state
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (slot_wrap) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Two-source scheduler for the 4-digit multiplexed 7-seg display.
// Arbitrates ownership at frame boundaries, snapshots the owner's digits and
// drives registered digit strobes / BCD nibble.
// Optional macro SEG_LZ_BLANK_EN enables leading-zero blanking of digits 3..1.
module seg_disp_sched
  import seg_disp_sched_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic        clk_24m,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  gnt,
  output logic [3:0]  digit_num,
  output logic [3:0]  sm_bit,
  output logic        busy
);

  localparam logic [24:0] HOLD_MAX = 25'(HOLD_CYC);

  state_t      state, state_next, disp_state;
  logic [24:0] hold_cnt;
  logic [15:0] snapshot, snap_next, disp_snap;
  logic [1:0]  digit_idx, idx_next;
  logic        slot_wrap, fb;
  logic [3:0]  strobe_next, num_next;

  seg_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk       (clk_24m),
    .rst       (rst),
    .digit_idx (digit_idx),
    .slot_wrap (slot_wrap),
    .fb        (fb)
  );

  // Ownership arbitration, only evaluated on the frame boundary
  always_comb begin
    state_next = state;
    if (fb) begin
      case (state)
        IDLE: begin
          if (req1)      state_next = OWN1;
          else if (req0) state_next = OWN0;
        end
        OWN0: begin
          if (!req0)                         state_next = req1 ? OWN1 : IDLE;
          else if (req1 && hold_cnt >= HOLD_MAX) state_next = OWN1;
        end
        OWN1: begin
          if (!req1) state_next = req0 ? OWN0 : IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Next slot contents; at the frame boundary the incoming owner's data is used directly
  always_comb begin
    case (state_next)
      OWN0:    snap_next = data0;
      OWN1:    snap_next = data1;
      default: snap_next = 16'd0;
    endcase
    idx_next    = digit_idx + 2'd1;
    disp_state  = fb ? state_next : state;
    disp_snap   = fb ? snap_next : snapshot;
    strobe_next = BLANK;
    num_next    = 4'd0;
    if (disp_state != IDLE) begin
      strobe_next = strobe_for(idx_next);
      num_next    = nibble_for(disp_snap, idx_next);
`ifdef SEG_LZ_BLANK_EN
      if (lead_zero(disp_snap, idx_next)) strobe_next = BLANK;
`endif
    end
  end

  // Owner state, hold timer, frame snapshot and registered display outputs
  always_ff @(posedge clk_24m) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      snapshot  <= 16'd0;
      gnt       <= 2'b00;
      busy      <= 1'b0;
      sm_bit    <= BLANK;
      digit_num <= 4'd0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        hold_cnt <= '0;
      end else if (state == OWN0 && hold_cnt < HOLD_MAX) begin
        hold_cnt <= hold_cnt + 25'd1;
      end
      if (fb) begin
        snapshot <= snap_next;
        gnt      <= gnt_for(state_next);
        busy     <= (state_next != IDLE);
      end
      if (slot_wrap) begin
        sm_bit    <= strobe_next;
        digit_num <= num_next;
      end
    end
  end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Self-checking bench for seg_disp_sched with SCAN_DIV=4, HOLD_CYC=40
// (slot every 4 cycles, frame boundary every 16). Honors SEG_LZ_BLANK_EN.
module tb_seg_disp_sched;

  logic        clk_24m = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] data0, data1;
  logic [1:0]  gnt;
  logic [3:0]  digit_num, sm_bit;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [3:0] EXP_S1 = 4'b1111;
  localparam logic [3:0] EXP_S2 = 4'b1111;
  localparam logic [3:0] EXP_S3 = 4'b1111;
`else
  localparam logic [3:0] EXP_S1 = 4'b1101;
  localparam logic [3:0] EXP_S2 = 4'b1011;
  localparam logic [3:0] EXP_S3 = 4'b0111;
`endif

  typedef struct {
    logic        r0;
    logic        r1;
    logic [15:0] d0;
    logic [15:0] d1;
    int          adv;
    logic [1:0]  gnt;
    logic [3:0]  sm;
    logic [3:0]  num;
    string       name;
  } vec_t;

  vec_t vecs[$];

  seg_disp_sched #(.SCAN_DIV(4), .HOLD_CYC(40)) dut (
    .clk_24m   (clk_24m),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .gnt       (gnt),
    .digit_num (digit_num),
    .sm_bit    (sm_bit),
    .busy      (busy)
  );

  always #5 clk_24m = ~clk_24m;

  task tick();
    @(posedge clk_24m);
    #1;
    cyc++;
  endtask

  task check_output(input string name, input logic [1:0] eg, input logic [3:0] es, input logic [3:0] en);
    logic eb;
    eb = |eg;
    n_cmp++;
    if ({gnt, busy, sm_bit, digit_num} !== {eg, eb, es, en}) begin
      n_bad++;
      $display("[TB] FAIL %s at cyc %0d: got gnt=%b busy=%b sm_bit=%b digit_num=%h, expected gnt=%b busy=%b sm_bit=%b digit_num=%h",
               name, cyc, gnt, busy, sm_bit, digit_num, eg, eb, es, en);
    end
  endtask

  task apply_stimulus(input vec_t v);
    req0  = v.r0;
    req1  = v.r1;
    data0 = v.d0;
    data1 = v.d1;
    repeat (v.adv) tick();
  endtask

  task add_vec(input logic r0, input logic r1, input logic [15:0] d0, input logic [15:0] d1,
               input int adv, input logic [1:0] g, input logic [3:0] s, input logic [3:0] n,
               input string name);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.adv = adv;
    v.gnt = g; v.sm = s; v.num = n; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 16'h0; data1 = 16'h0;

    // cycle numbers in comments are edges counted from reset release; FB at multiples of 16
    add_vec(1, 0, 16'h1234, 16'h0000, 15, 2'b00, 4'b1111, 4'h0, "pre_grant");      // 79
    add_vec(1, 0, 16'h1234, 16'h0000,  1, 2'b01, 4'b1110, 4'h4, "grant0_slot0");   // 80
    add_vec(1, 0, 16'h1234, 16'h0000,  3, 2'b01, 4'b1110, 4'h4, "slot0_held");     // 83
    add_vec(1, 0, 16'h1234, 16'h0000,  1, 2'b01, 4'b1101, 4'h3, "slot1");          // 84
    add_vec(1, 0, 16'h1234, 16'h0000,  4, 2'b01, 4'b1011, 4'h2, "slot2");          // 88
    add_vec(1, 0, 16'h1234, 16'h0000,  4, 2'b01, 4'b0111, 4'h1, "slot3");          // 92
    add_vec(1, 0, 16'h1234, 16'h0000,  4, 2'b01, 4'b1110, 4'h4, "frame2_slot0");   // 96
    add_vec(0, 0, 16'h1234, 16'h0000, 16, 2'b00, 4'b1111, 4'h0, "release_idle");   // 112
    add_vec(1, 1, 16'h1234, 16'h90AF, 16, 2'b10, 4'b1110, 4'hF, "simul_grant1");   // 128
    add_vec(1, 1, 16'h1234, 16'h90AF,  4, 2'b10, 4'b1101, 4'hA, "src1_slot1");     // 132
    add_vec(1, 1, 16'h1234, 16'h90AF,  4, 2'b10, 4'b1011, 4'h0, "src1_slot2");     // 136
    add_vec(1, 1, 16'h1234, 16'h90AF,  4, 2'b10, 4'b0111, 4'h9, "src1_slot3");     // 140
    add_vec(1, 0, 16'h1234, 16'h90AF,  4, 2'b01, 4'b1110, 4'h4, "fallback_src0");  // 144
    add_vec(1, 0, 16'h1234, 16'h90AF,  5, 2'b01, 4'b1101, 4'h3, "src0_again");     // 149
    add_vec(1, 1, 16'h1234, 16'h90AF, 11, 2'b01, 4'b1110, 4'h4, "hold15_keep0");   // 160
    add_vec(1, 1, 16'h1234, 16'h90AF, 16, 2'b01, 4'b1110, 4'h4, "hold31_keep0");   // 176
    add_vec(1, 1, 16'h1234, 16'h90AF, 16, 2'b10, 4'b1110, 4'hF, "hold47_preempt"); // 192

    // reset held for three edges, then an idle scan of four frames
    repeat (3) tick();
    check_output("reset", 2'b00, 4'b1111, 4'h0);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      check_output("idle_scan", 2'b00, 4'b1111, 4'h0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i].name, vecs[i].gnt, vecs[i].sm, vecs[i].num);
    end

    // back to src0 showing 1234, then change data during digit1 slot
    req1 = 1'b0; req0 = 1'b1; data0 = 16'h1234;
    repeat (16) tick();
    check_output("regrant0", 2'b01, 4'b1110, 4'h4);        // 208
    repeat (4) tick();
    check_output("snap_slot1", 2'b01, 4'b1101, 4'h3);      // 212
    tick();
    data0 = 16'h5678;                                       // 213
    repeat (3) tick();
    check_output("snap_slot2_old", 2'b01, 4'b1011, 4'h2);  // 216
    repeat (4) tick();
    check_output("snap_slot3_old", 2'b01, 4'b0111, 4'h1);  // 220
    repeat (4) tick();
    check_output("snap_new_d0", 2'b01, 4'b1110, 4'h8);     // 224
    repeat (4) tick();
    check_output("snap_new_d1", 2'b01, 4'b1101, 4'h7);     // 228
    repeat (4) tick();
    check_output("snap_new_d2", 2'b01, 4'b1011, 4'h6);     // 232
    repeat (4) tick();
    check_output("snap_new_d3", 2'b01, 4'b0111, 4'h5);     // 236

    // leading zeros
    data0 = 16'h0007;
    repeat (4) tick();
    check_output("lz_slot0", 2'b01, 4'b1110, 4'h7);        // 240
    repeat (4) tick();
    check_output("lz_slot1", 2'b01, EXP_S1, 4'h0);         // 244
    repeat (4) tick();
    check_output("lz_slot2", 2'b01, EXP_S2, 4'h0);         // 248
    repeat (4) tick();
    check_output("lz_slot3", 2'b01, EXP_S3, 4'h0);         // 252

    // reset in the middle of a frame
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_output("mid_reset", 2'b00, 4'b1111, 4'h0);
    rst = 1'b0;
    cyc = 0;
    repeat (4) tick();
    check_output("post_reset", 2'b00, 4'b1111, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
